// File: rtl/job_fifo_dispatcher.sv
// Read-side consumer of job_fifo: pops one descriptor, hands it to the engine, then waits for done or watchdog.
// Optional completion/timeout counters are enabled with the JOB_DISP_STATS_EN macro.
module job_fifo_dispatcher #(
   parameter int DATA_WIDTH     = 128,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_WIDTH       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  job_valid,
   output logic [DATA_WIDTH-1:0] job_data,
   input  logic                  job_ready,
   input  logic                  eng_done,
   output logic                  busy,
   output logic                  err_timeout,
   input  logic                  err_clr
`ifdef JOB_DISP_STATS_EN
   ,
   output logic [31:0]           jobs_done,
   output logic [15:0]           jobs_timed_out
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;
   localparam logic [1:0] BUSY  = 2'd3;

   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]          state;
   logic [TO_WIDTH-1:0] watchdog;
   logic                done_hit;
   logic                timeout_hit;

   // eng_done takes priority over an expiring watchdog in the same cycle
   assign done_hit    = (state == BUSY) && eng_done;
   assign timeout_hit = (state == BUSY) && !eng_done && (watchdog >= TO_LAST);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fifo_rd_en <= 1'b0;
         job_valid  <= 1'b0;
         job_data   <= '0;
         watchdog   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en && !fifo_empty) begin
                  fifo_rd_en <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               // first FETCH cycle drops the strobe; read data lands one cycle later
               if (fifo_rd_en) begin
                  fifo_rd_en <= 1'b0;
               end else begin
                  job_data  <= fifo_rd_data;
                  job_valid <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (job_ready) begin
                  job_valid <= 1'b0;
                  watchdog  <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (watchdog != '1)
                  watchdog <= watchdog + 1'b1;
               if (done_hit || timeout_hit)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_timeout <= 1'b0;
      else if (timeout_hit)
         err_timeout <= 1'b1;
      else if (err_clr)
         err_timeout <= 1'b0;
   end

`ifdef JOB_DISP_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         jobs_done      <= '0;
         jobs_timed_out <= '0;
      end else begin
         if (done_hit)
            jobs_done <= jobs_done + 32'd1;
         if (timeout_hit)
            jobs_timed_out <= jobs_timed_out + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_job_fifo_dispatcher.sv
// Randomized scoreboard bench for job_fifo_dispatcher with a queue-backed FIFO model and an independent monitor.
// Stats counters are compared when JOB_DISP_STATS_EN is defined.
module tb_job_fifo_dispatcher;
   localparam int DW = 128;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          job_ready = 1'b0;
   logic          eng_done = 1'b0;
   logic          err_clr = 1'b0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          job_valid;
   logic [DW-1:0] job_data;
   logic          busy;
   logic          err_timeout;
`ifdef JOB_DISP_STATS_EN
   logic [31:0]   jobs_done;
   logic [15:0]   jobs_timed_out;
`endif

   job_fifo_dispatcher #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .job_valid(job_valid), .job_data(job_data),
      .job_ready(job_ready), .eng_done(eng_done), .busy(busy), .err_timeout(err_timeout),
      .err_clr(err_clr)
`ifdef JOB_DISP_STATS_EN
      , .jobs_done(jobs_done), .jobs_timed_out(jobs_timed_out)
`endif
   );

   always #5 clk = ~clk;

   // FIFO model: read data registered one cycle after the strobe; not rewound by DUT reset
   logic [DW-1:0] fifo_mem [0:255];
   int push_cnt = 0;
   int pop_cnt  = 0;
   int cyc      = 0;
   assign fifo_empty = (push_cnt == pop_cnt);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         fifo_rd_data <= fifo_mem[pop_cnt[7:0]];
         pop_cnt      <= pop_cnt + 1;
      end
   end

   logic [DW-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;
   int n_done = 0;
   int n_to   = 0;
   int rd_pulses = 0;

   task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each handshake and checks protocol timing
   initial begin
      logic prev_valid, prev_rd, prev_err, prev_hs, hs, tracking;
      logic [DW-1:0] prev_data;
      int rd_edge, accept_edge;
      prev_valid = 1'b0; prev_rd = 1'b0; prev_err = 1'b0; prev_hs = 1'b0; tracking = 1'b0;
      prev_data = '0; rd_edge = -100; accept_edge = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0; prev_rd = 1'b0; prev_err = 1'b0; prev_hs = 1'b0; tracking = 1'b0;
         end else begin
            if (fifo_rd_en) begin
               rd_pulses++;
               rd_edge = cyc;
               chk_b("rd_when_not_empty", fifo_empty, 1'b0);
               chk_b("rd_single_pulse", prev_rd, 1'b0);
            end
            if (job_valid && !prev_valid)
               chk_i("issue_latency", cyc - rd_edge, 2);
            if (prev_valid && !prev_hs) begin
               chk_b("valid_hold", job_valid, 1'b1);
               chk_d("data_hold", job_data, prev_data);
            end
            if (err_timeout && !prev_err) begin
               if (tracking) begin
                  chk_i("timeout_cycles", cyc - accept_edge, TO);
               end else begin
                  errors++;
                  $display("FAIL unexpected_timeout actual=1 required=0 cyc=%0d", cyc);
               end
               tracking = 1'b0;
            end
            if (tracking && (cyc - accept_edge >= TO)) begin
               errors++;
               $display("FAIL timeout_missing actual=0 required=1 cyc=%0d", cyc);
               tracking = 1'b0;
            end
            if (tracking && eng_done)
               tracking = 1'b0;
            hs = job_valid && job_ready;
            if (hs) begin
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL job_data actual=%0h required=none", job_data);
               end else begin
                  chk_d("job_data", job_data, exp_q.pop_front());
               end
               tracking    = 1'b1;
               accept_edge = cyc + 1;
            end
            prev_valid = job_valid;
            prev_data  = job_data;
            prev_rd    = fifo_rd_en;
            prev_err   = err_timeout;
            prev_hs    = hs;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      fifo_mem[push_cnt[7:0]] = d;
      push_cnt++;
      exp_q.push_back(d);
   endtask

   task automatic run_job(input logic [DW-1:0] d, input int rdy_dly, input int done_dly,
                          input bit give_done, input bit do_push);
      int n;
      bit busy_ok;
      if (do_push) push(d);
      n = 0;
      while (!job_valid && n < 20) begin
         step();
         n++;
      end
      if (!job_valid) begin
         errors++;
         $display("FAIL wait_job_valid actual=0 required=1 job=%0h", d);
         return;
      end
      job_ready = 1'b0;
      repeat (rdy_dly) step();
      job_ready = 1'b1;
      step();
      job_ready = 1'b0;
      chk_b("accepted", job_valid, 1'b0);
      chk_b("busy_after_accept", busy, 1'b1);
      if (give_done) begin
         busy_ok = 1'b1;
         repeat (done_dly) begin
            step();
            if (!busy) busy_ok = 1'b0;
         end
         chk_b("busy_until_done", busy_ok, 1'b1);
         eng_done = 1'b1;
         step();
         eng_done = 1'b0;
         chk_b("idle_after_done", busy, 1'b0);
         chk_b("no_err_on_done", err_timeout, 1'b0);
         n_done++;
      end else begin
         n = 0;
         while (busy && n < 30) begin
            step();
            n++;
         end
         chk_b("idle_after_timeout", busy, 1'b0);
         chk_b("err_set", err_timeout, 1'b1);
         err_clr = 1'b1;
         step();
         err_clr = 1'b0;
         chk_b("err_cleared", err_timeout, 1'b0);
         n_to++;
      end
      step();
   endtask

   initial begin
      int base;
      bit quiet;
      int n;
      repeat (3) step();
      chk_b("rst_rd_en", fifo_rd_en, 1'b0);
      chk_b("rst_job_valid", job_valid, 1'b0);
      chk_d("rst_job_data", job_data, '0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_err", err_timeout, 1'b0);
      rst = 1'b0;
      en  = 1'b1;
      step();

      // Three queued jobs drained in order
      base = rd_pulses;
      push(128'h11); push(128'h22); push(128'h33);
      run_job(128'h11, 0, 2, 1'b1, 1'b0);
      run_job(128'h22, 0, 2, 1'b1, 1'b0);
      run_job(128'h33, 0, 2, 1'b1, 1'b0);
      chk_i("rd_pulses", rd_pulses - base, 3);
      chk_b("fifo_empty_end", fifo_empty, 1'b1);
      chk_b("err_after_three", err_timeout, 1'b0);

      // Enabled with an empty FIFO: nothing moves
      quiet = 1'b1;
      repeat (20) begin
         step();
         if (fifo_rd_en || busy || job_valid) quiet = 1'b0;
      end
      chk_b("empty_fifo_quiet", quiet, 1'b1);

      // Disabled with a job waiting: nothing moves until en rises
      en = 1'b0;
      push(128'h77);
      quiet = 1'b1;
      repeat (6) begin
         step();
         if (fifo_rd_en || busy) quiet = 1'b0;
      end
      chk_b("disabled_quiet", quiet, 1'b1);
      en = 1'b1;
      run_job(128'h77, 0, 1, 1'b1, 1'b0);

      // Engine backpressure, a watchdog expiry, and done on the last legal cycle
      run_job(128'hABCD, 5, 3, 1'b1, 1'b1);
      run_job(128'hDEAD, 0, 0, 1'b0, 1'b1);
      run_job(128'hBEEF, 1, TO - 1, 1'b1, 1'b1);

      // Reset while a descriptor sits in ISSUE
      push(128'h55);
      n = 0;
      while (!job_valid && n < 20) begin
         step();
         n++;
      end
      step();
      rst = 1'b1;
      #1;
      chk_b("async_rst_valid", job_valid, 1'b0);
      chk_b("async_rst_busy", busy, 1'b0);
      chk_d("async_rst_data", job_data, '0);
      void'(exp_q.pop_front());
      n_done = 0;
      n_to   = 0;
      push(128'h66);
      step();
      step();
      rst = 1'b0;
      run_job(128'h66, 0, 2, 1'b1, 1'b0);

      for (int i = 0; i < 16; i++) begin
         run_job({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, TO - 1)), ($urandom_range(0, 4) != 0), 1'b1);
      end

      chk_i("scoreboard_drained", exp_q.size(), 0);
`ifdef JOB_DISP_STATS_EN
      chk_i("jobs_done", int'(jobs_done), n_done);
      chk_i("jobs_timed_out", int'(jobs_timed_out), n_to);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL global_time_limit actual=expired required=done");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
